// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I execute core: datapath widths and the
// ALU operation codes driven by the decode unit on alu_cntrl.
package rv32_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] ALU_ADD   = 6'b000001;
  localparam logic [5:0] ALU_SUB   = 6'b000010;
  localparam logic [5:0] ALU_SLL   = 6'b000011;
  localparam logic [5:0] ALU_SLT   = 6'b000100;
  localparam logic [5:0] ALU_SLTU  = 6'b000101;
  localparam logic [5:0] ALU_XOR   = 6'b000110;
  localparam logic [5:0] ALU_SRL   = 6'b000111;
  localparam logic [5:0] ALU_SRA   = 6'b001000;
  localparam logic [5:0] ALU_OR    = 6'b001001;
  localparam logic [5:0] ALU_AND   = 6'b001010;
  localparam logic [5:0] ALU_ADDI  = 6'b001011;
  localparam logic [5:0] ALU_SLTI  = 6'b001100;
  localparam logic [5:0] ALU_SLTIU = 6'b001101;
  localparam logic [5:0] ALU_XORI  = 6'b001110;
  localparam logic [5:0] ALU_ORI   = 6'b001111;
  localparam logic [5:0] ALU_ANDI  = 6'b010000;
  localparam logic [5:0] ALU_SLLI  = 6'b010001;
  localparam logic [5:0] ALU_SRLI  = 6'b010010;
  localparam logic [5:0] ALU_SRAI  = 6'b010011;
  localparam logic [5:0] ALU_EQ    = 6'b010100;
  localparam logic [5:0] ALU_NE    = 6'b010101;
  localparam logic [5:0] ALU_GE    = 6'b010110;
  localparam logic [5:0] ALU_LT    = 6'b010111;
  localparam logic [5:0] ALU_ADDR  = 6'b011000;
endpackage

// File: rtl/rv32_alu.sv
// Combinational ALU.
// Ports: a/b (rs1/rs2 values), imm (sign-extended immediate), shamt
// (immediate shift amount), op (operation select) -> result.
// Compare/set operations return 32'd1 or 32'd0; unknown codes return 0.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      shamt,
  input  logic [5:0]      op,
  output logic [XLEN-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'b0, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $signed(a) >>> b[4:0];
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_ADDI:  result = a + imm;
      ALU_SLTI:  result = {31'b0, $signed(a) < $signed(imm)};
      ALU_SLTIU: result = {31'b0, a < imm};
      ALU_XORI:  result = a ^ imm;
      ALU_ORI:   result = a | imm;
      ALU_ANDI:  result = a & imm;
      ALU_SLLI:  result = a << shamt;
      ALU_SRLI:  result = a >> shamt;
      ALU_SRAI:  result = $signed(a) >>> shamt;
      ALU_EQ:    result = {31'b0, a == b};
      ALU_NE:    result = {31'b0, a != b};
      ALU_GE:    result = {31'b0, $signed(a) >= $signed(b)};
      ALU_LT:    result = {31'b0, $signed(a) < $signed(b)};
      ALU_ADDR:  result = a + imm;
      default:   result = '0;
    endcase
  end
endmodule

// File: rtl/rv32_exec_core.sv
// Execute/storage core of the RV32I microcontroller.
// Holds the register file, data memory, writeback mux and timer config
// registers; instantiates the combinational ALU.
// Ports: clk/reset (async, active high); rs1/rs2/rd indices and control
// strobes from decode; read_data1/2, ALU result, data memory word address,
// branch-taken flags, and TIM_PSC/TIM_ARR for the timer peripheral.
module rv32_exec_core
  import rv32_pkg::*;
#(
  parameter int NREGS      = 32,
  parameter int DMEM_WORDS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] read_reg_num1,
  input  logic [REG_ADDR_W-1:0] read_reg_num2,
  input  logic [REG_ADDR_W-1:0] write_reg_num,
  input  logic                  reg_wr_en,
  input  logic [5:0]            alu_cntrl,
  input  logic [XLEN-1:0]       imm_val,
  input  logic [4:0]            shamt,
  input  logic                  mem_to_reg,
  input  logic                  sw,
  input  logic                  lui_cntrl,
  input  logic [XLEN-1:0]       imm_val_lui,
  input  logic                  jump,
  input  logic [XLEN-1:0]       return_address,
  input  logic                  beq_cntrl,
  input  logic                  bneq_cntrl,
  input  logic                  bge_cntrl,
  input  logic                  blt_cntrl,
  input  logic                  timer_en,
  input  logic                  timer_reg_en,
  output logic [XLEN-1:0]       read_data1,
  output logic [XLEN-1:0]       read_data2,
  output logic [XLEN-1:0]       write_data_alu,
  output logic [4:0]            read_data_addr_dm,
  output logic                  beq,
  output logic                  bneq,
  output logic                  bge,
  output logic                  blt,
  output logic [15:0]           TIM_PSC,
  output logic [15:0]           TIM_ARR
);
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] wb_data;

  // x0 is forced to zero on read; it is also never written.
  assign read_data1 = (read_reg_num1 == '0) ? '0 : regs[read_reg_num1];
  assign read_data2 = (read_reg_num2 == '0) ? '0 : regs[read_reg_num2];

  rv32_alu u_alu (
    .a      (read_data1),
    .b      (read_data2),
    .imm    (imm_val),
    .shamt  (shamt),
    .op     (alu_cntrl),
    .result (write_data_alu)
  );

  // Word-indexed; upper ALU bits are dropped so addresses wrap mod 32.
  assign read_data_addr_dm = write_data_alu[4:0];
  assign mem_rdata         = dmem[read_data_addr_dm];

  always_comb begin
    wb_data = write_data_alu;
    if (jump)            wb_data = return_address;
    else if (lui_cntrl)  wb_data = imm_val_lui;
    else if (mem_to_reg) wb_data = mem_rdata;
  end

  assign beq  = beq_cntrl  & (write_data_alu == 32'd1);
  assign bneq = bneq_cntrl & (write_data_alu == 32'd1);
  assign bge  = bge_cntrl  & (write_data_alu == 32'd1);
  assign blt  = blt_cntrl  & (write_data_alu == 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_wr_en && write_reg_num != '0) begin
      regs[write_reg_num] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else if (sw) begin
      dmem[read_data_addr_dm] <= read_data2;
    end
  end

  // The ALU result acts as the register selector for timer config writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      TIM_PSC <= '0;
      TIM_ARR <= '0;
    end else if (timer_en && timer_reg_en) begin
      if (write_data_alu == 32'd1)      TIM_PSC <= read_data1[15:0];
      else if (write_data_alu == 32'd2) TIM_ARR <= read_data1[15:0];
    end
  end
endmodule

// File: tb/tb_rv32_exec_core.sv
module tb_rv32_exec_core;
  logic        clk, reset;
  logic [4:0]  rs1, rs2, rd;
  logic        we;
  logic [5:0]  op;
  logic [31:0] imm;
  logic [4:0]  sh;
  logic        m2r, sw, lui;
  logic [31:0] luiv;
  logic        jmp;
  logic [31:0] ra;
  logic        bc_eq, bc_ne, bc_ge, bc_lt, ten, treg;
  logic [31:0] read_data1, read_data2, write_data_alu;
  logic [4:0]  read_data_addr_dm;
  logic        beq, bneq, bge, blt;
  logic [15:0] TIM_PSC, TIM_ARR;

  int errors = 0;
  int checks = 0;

  logic [31:0] rm [32];
  logic [31:0] mm [32];
  logic [15:0] psc_m, arr_m;

  rv32_exec_core dut (
    .clk(clk), .reset(reset),
    .read_reg_num1(rs1), .read_reg_num2(rs2), .write_reg_num(rd),
    .reg_wr_en(we), .alu_cntrl(op), .imm_val(imm), .shamt(sh),
    .mem_to_reg(m2r), .sw(sw), .lui_cntrl(lui), .imm_val_lui(luiv),
    .jump(jmp), .return_address(ra),
    .beq_cntrl(bc_eq), .bneq_cntrl(bc_ne), .bge_cntrl(bc_ge), .blt_cntrl(bc_lt),
    .timer_en(ten), .timer_reg_en(treg),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_data_alu(write_data_alu), .read_data_addr_dm(read_data_addr_dm),
    .beq(beq), .bneq(bneq), .bge(bge), .blt(blt),
    .TIM_PSC(TIM_PSC), .TIM_ARR(TIM_ARR)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the operation table with integer arithmetic.
  function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a, b, i,
                                          input logic [4:0] s);
    int sa, sb, si;
    sa = int'(a); sb = int'(b); si = int'(i);
    case (code)
      1:  return a + b;
      2:  return a - b;
      3:  return a << b[4:0];
      4:  return (sa < sb) ? 32'd1 : 32'd0;
      5:  return (a < b) ? 32'd1 : 32'd0;
      6:  return a ^ b;
      7:  return a >> b[4:0];
      8:  return 32'(sa >>> b[4:0]);
      9:  return a | b;
      10: return a & b;
      11: return a + i;
      12: return (sa < si) ? 32'd1 : 32'd0;
      13: return (a < i) ? 32'd1 : 32'd0;
      14: return a ^ i;
      15: return a | i;
      16: return a & i;
      17: return a << s;
      18: return a >> s;
      19: return 32'(sa >>> s);
      20: return (a == b) ? 32'd1 : 32'd0;
      21: return (a != b) ? 32'd1 : 32'd0;
      22: return (sa >= sb) ? 32'd1 : 32'd0;
      23: return (sa < sb) ? 32'd1 : 32'd0;
      24: return a + i;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clr();
    rs1 = 0; rs2 = 0; rd = 0; we = 0; op = 0; imm = 0; sh = 0;
    m2r = 0; sw = 0; lui = 0; luiv = 0; jmp = 0; ra = 0;
    bc_eq = 0; bc_ne = 0; bc_ge = 0; bc_lt = 0; ten = 0; treg = 0;
  endtask

  // Checks all combinational outputs against the model, clocks once,
  // then advances the model. Entered 1 time unit after a rising edge.
  task automatic step();
    logic [31:0] a, b, res, wb;
    #1;
    a   = (rs1 == 0) ? 32'd0 : rm[rs1];
    b   = (rs2 == 0) ? 32'd0 : rm[rs2];
    res = ref_alu(int'(op), a, b, imm, sh);
    chk("rd1", read_data1, a);
    chk("rd2", read_data2, b);
    chk("alu", write_data_alu, res);
    chk("addr", {27'b0, read_data_addr_dm}, {27'b0, res[4:0]});
    chk("beq",  {31'b0, beq},  {31'b0, bc_eq && res == 1});
    chk("bneq", {31'b0, bneq}, {31'b0, bc_ne && res == 1});
    chk("bge",  {31'b0, bge},  {31'b0, bc_ge && res == 1});
    chk("blt",  {31'b0, blt},  {31'b0, bc_lt && res == 1});
    chk("psc", {16'b0, TIM_PSC}, {16'b0, psc_m});
    chk("arr", {16'b0, TIM_ARR}, {16'b0, arr_m});
    if (jmp) wb = ra;
    else if (lui) wb = luiv;
    else if (m2r) wb = mm[res % 32];
    else wb = res;
    @(posedge clk);
    if (we && rd != 0) rm[rd] = wb;
    if (sw) mm[res % 32] = b;
    if (ten && treg) begin
      if (res == 1) psc_m = a[15:0];
      else if (res == 2) arr_m = a[15:0];
    end
    #1;
  endtask

  task automatic read_reg(input logic [4:0] r, input string tag, input logic [31:0] exp);
    clr(); rs1 = r; #1;
    chk(tag, read_data1, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin rm[i] = 0; mm[i] = 0; end
    psc_m = 0; arr_m = 0;
    clr();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); #1;
      chk("rst_reg", read_data1, 32'd0);
    end
    chk("rst_psc", {16'b0, TIM_PSC}, 32'd0);
    chk("rst_arr", {16'b0, TIM_ARR}, 32'd0);
    @(posedge clk); #1;
    reset = 0; clr();
    @(posedge clk); #1;

    // ADDI x1=5, ADDI x2=-3, SUB x3=x1-x2
    clr(); op = 6'b001011; imm = 5; rd = 1; we = 1; step();
    clr(); op = 6'b001011; imm = -32'sd3; rd = 2; we = 1; step();
    clr(); op = 6'b000010; rs1 = 1; rs2 = 2; rd = 3; we = 1; step();
    read_reg(3, "sub_x3", 32'd8);
    clr(); op = 6'b000100; rs1 = 2; rs2 = 1; step();
    chk("slt", write_data_alu, 32'd1);
    clr(); op = 6'b000101; rs1 = 2; rs2 = 1; step();
    chk("sltu", write_data_alu, 32'd0);
    // Same-cycle read of the register being written returns the old value.
    clr(); op = 6'b010011; rs1 = 2; sh = 1; rd = 2; we = 1; step();
    read_reg(2, "srai", 32'hFFFFFFFE);

    // x0 stays zero
    clr(); lui = 1; luiv = 32'hDEAD; rd = 0; we = 1; step();
    read_reg(0, "x0", 32'd0);

    // Store / load round trip, including wrapped address
    clr(); lui = 1; luiv = 32'h12345678; rd = 4; we = 1; step();
    clr(); op = 6'b001011; imm = 3; rd = 5; we = 1; step();
    clr(); op = 6'b011000; rs1 = 5; rs2 = 4; sw = 1; step();
    chk("st_addr", {27'b0, read_data_addr_dm}, 32'd3);
    clr(); op = 6'b011000; rs1 = 5; m2r = 1; rd = 6; we = 1; step();
    read_reg(6, "load", 32'h12345678);
    clr(); op = 6'b001011; imm = 35; m2r = 1; rd = 7; we = 1; step();
    read_reg(7, "wrap", 32'h12345678);

    // Branch flags
    clr(); op = 6'b001011; imm = 5; rd = 7; we = 1; step();
    clr(); op = 6'b001011; imm = -32'sd3; rd = 2; we = 1; step();
    clr(); op = 6'b010100; rs1 = 1; rs2 = 7; bc_eq = 1; step();
    chk("beq_t", {31'b0, beq}, 32'd1);
    clr(); op = 6'b010100; rs1 = 1; rs2 = 7; step();
    chk("beq_off", {31'b0, beq}, 32'd0);
    clr(); op = 6'b010110; rs1 = 2; rs2 = 1; bc_ge = 1; step();
    chk("bge", {31'b0, bge}, 32'd0);
    clr(); op = 6'b010111; rs1 = 2; rs2 = 1; bc_lt = 1; step();
    chk("blt", {31'b0, blt}, 32'd1);

    // Writeback priority: jump over lui
    clr(); jmp = 1; ra = 32'h100; lui = 1; luiv = 32'h5000; rd = 8; we = 1; step();
    read_reg(8, "jump_prio", 32'h100);

    // Timer registers
    clr(); lui = 1; luiv = 32'h0001ABCD; rd = 9; we = 1; step();
    clr(); op = 6'b010100; rs1 = 9; rs2 = 9; ten = 1; treg = 1; step();
    chk("psc_ld", {16'b0, TIM_PSC}, 32'h0000ABCD);
    clr(); op = 6'b011000; rs1 = 9; imm = 32'd2 - 32'h0001ABCD; ten = 1; treg = 1; step();
    chk("arr_ld", {16'b0, TIM_ARR}, 32'h0000ABCD);
    clr(); op = 6'b010100; rs1 = 1; rs2 = 1; ten = 0; treg = 1; step();
    chk("psc_hold", {16'b0, TIM_PSC}, 32'h0000ABCD);

    // Randomized operation against the model
    for (int n = 0; n < 300; n++) begin
      rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1));
      op = 6'($urandom_range(0, 31)); imm = $urandom; sh = 5'($urandom_range(0, 31));
      m2r = 1'($urandom_range(0, 1)); sw = ($urandom_range(0, 3) == 0);
      lui = ($urandom_range(0, 7) == 0); luiv = $urandom;
      jmp = ($urandom_range(0, 7) == 0); ra = $urandom;
      bc_eq = 1'($urandom_range(0, 1)); bc_ne = 1'($urandom_range(0, 1));
      bc_ge = 1'($urandom_range(0, 1)); bc_lt = 1'($urandom_range(0, 1));
      ten = 1'($urandom_range(0, 1)); treg = 1'($urandom_range(0, 1));
      step();
    end

    // Reset asserted between edges: state clears at once, writes blocked
    clr(); lui = 1; luiv = 32'hCAFE0001; rd = 5; we = 1; sw = 1;
    #2;
    reset = 1;
    #1;
    chk("mid_psc", {16'b0, TIM_PSC}, 32'd0);
    chk("mid_arr", {16'b0, TIM_ARR}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); #1;
      chk("mid_reg", read_data1, 32'd0);
    end
    rs1 = 5; #1;
    chk("mid_blk", read_data1, 32'd0);
    for (int i = 0; i < 32; i++) begin rm[i] = 0; mm[i] = 0; end
    psc_m = 0; arr_m = 0;
    @(negedge clk);
    reset = 0; clr();
    @(posedge clk); #1;
    clr(); op = 6'b001011; imm = 3; m2r = 1; rd = 10; we = 1; step();
    read_reg(10, "mem_clr", 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32_exec_core.md
Name: rv32_exec_core

Overview:
- Execute/storage core of the RV32I microcontroller: 32x32 register file, combinational ALU, 32-word data memory, branch-condition flags and timer configuration registers (prescaler, auto-reload).
- Sits between the control/decode unit (which supplies register numbers, immediates and control strobes) and the timer peripheral.
- Produces the ALU result and the branch-taken flags for the PC logic.

Parameters:
- NREGS, 32, number of architectural registers (x0 hardwired to zero).
- DMEM_WORDS, 32, data memory depth in 32-bit words.

Ports:
- clk  in  1  system clock; all writes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- read_reg_num1  in  5  rs1 index.
- read_reg_num2  in  5  rs2 index.
- write_reg_num  in  5  rd index.
- reg_wr_en  in  1  register write enable.
- alu_cntrl  in  6  ALU operation select.
- imm_val  in  32  sign-extended immediate.
- shamt  in  5  immediate shift amount.
- mem_to_reg  in  1  writeback selects memory read data (load).
- sw  in  1  data memory write strobe.
- lui_cntrl  in  1  writeback selects imm_val_lui.
- imm_val_lui  in  32  LUI value (imm << 12, pre-shifted).
- jump  in  1  writeback selects return_address.
- return_address  in  32  PC+4 for JAL/JALR.
- beq_cntrl, bneq_cntrl, bge_cntrl, blt_cntrl  in  1 each  branch type strobes.
- timer_en, timer_reg_en  in  1 each  timer configuration write qualifiers.
- read_data1, read_data2  out  32  rs1/rs2 values.
- write_data_alu  out  32  ALU result.
- read_data_addr_dm  out  5  current data memory word address.
- beq, bneq, bge, blt  out  1 each  branch-taken flags.
- TIM_PSC, TIM_ARR  out  16 each  timer prescaler and auto-reload registers.

Behaviour:
- Register file:
  - Reads are combinational; reading x0 returns 0.
  - Writes happen on posedge when reg_wr_en=1 and write_reg_num!=0.
  - Writeback data priority: jump → return_address; else lui_cntrl → imm_val_lui; else mem_to_reg → memory read data; else write_data_alu.
  - Reading and writing the same register in one cycle returns the old value; the new value is visible the next cycle.
- ALU (combinational, A=read_data1, B=read_data2, I=imm_val, arithmetic mod 2^32):
  - 000001 ADD; 000010 SUB; 000011 SLL B[4:0]; 000100 SLT signed; 000101 SLTU; 000110 XOR; 000111 SRL B[4:0]; 001000 SRA B[4:0]; 001001 OR; 001010 AND.
  - 001011 ADDI; 001100 SLTI; 001101 SLTIU; 001110 XORI; 001111 ORI; 010000 ANDI (all use I).
  - 010001 SLLI, 010010 SRLI, 010011 SRAI (all use shamt).
  - 010100 EQ (1 if A==B); 010101 NE; 010110 GE signed; 010111 LT signed.
  - 011000 ADDR = A+I.
  - Any other code returns 0.
  - Compare and set ops return 32'd1 or 32'd0.
- Data memory:
  - Word address = write_data_alu[4:0] (word-indexed), driven on read_data_addr_dm.
  - Read is combinational.
  - Write of read_data2 occurs on posedge when sw=1.
  - Read and write to the same address in one cycle returns the old word.
  - Addresses wrap modulo 32.
- Branch flags (combinational): beq = beq_cntrl & (write_data_alu==1); bneq, bge and blt are formed the same way from their own strobes. All flags are 0 when their strobe is 0.
- Timer registers:
  - Updated on posedge only when timer_en & timer_reg_en.
  - write_data_alu==1 loads TIM_PSC ← read_data1[15:0].
  - write_data_alu==2 loads TIM_ARR ← read_data1[15:0].
  - Any other result: no change.
- Reset (asynchronous, mid-operation included):
  - All registers, all memory words, TIM_PSC and TIM_ARR go to 0 immediately.
  - Writes are blocked while reset is high.
  - Combinational outputs follow from the zeroed state.

Decomposition:
- Shared package rv32_pkg holds the ALU opcode constants (localparams above), plus XLEN=32 and REG_ADDR_W=5.
- One natural sub-module: rv32_alu (pure combinational).
- Register file, memory, writeback mux and timer registers stay in the top.

Test Plan:
- Reset, then read all 32 registers → every read_data1 = 0; TIM_PSC = TIM_ARR = 0.
- ADDI x1 = x0 + 5 (alu 001011, imm 5, reg_wr_en); ADDI x2 = x0 − 3; then SUB x3 = x1 − x2 → x3 = 8. SLT(x2,x1) = 1; SLTU(x2,x1) = 0. SRAI x2 by 1 → 0xFFFFFFFE.
- Write to x0 with 0xDEAD → x0 still reads 0.
- Store/load round trip:
  - Set x4 = 0x12345678, x5 = 3.
  - ADDR with rs1 = x5, imm 0, sw=1 → read_data_addr_dm = 3, mem[3] written.
  - Load (mem_to_reg) into x6 → x6 = 0x12345678.
  - Address 35 wraps to word 3.
- Branches:
  - x1 = x7 = 5 with EQ op and beq_cntrl=1 → beq=1. Same op with beq_cntrl=0 → beq=0.
  - GE(−3, 5) with bge_cntrl → bge=0. LT(−3, 5) with blt_cntrl → blt=1.
- Writeback priority and timer:
  - jump=1 with lui_cntrl=1 → rd = return_address.
  - rs1 = 0x1_ABCD, ALU result 1, timer_en=timer_reg_en=1 → TIM_PSC = 0xABCD.
  - ALU result 2 → TIM_ARR loaded.
  - timer_en=0 → no change.
  - Assert reset between clock edges → PSC/ARR/registers read 0 immediately.
